// File: rtl/insn_fetch_queue_pkg.sv
// Shared fetch-path types, widths and sizing constants.
package insn_fetch_queue_pkg;

    // Datapath widths shared with the program counter and decode.
    localparam int INSN_ADDR_PATH = 32;
    localparam int INSN_PATH      = 32;

    // Program counter reset vector and sequential increment.
    localparam logic [INSN_ADDR_PATH-1:0] INSN_RESET_VECTOR = 32'h0000_0000;
    localparam logic [INSN_ADDR_PATH-1:0] INSN_PC_INC       = 32'h0000_0004;

    // Fetch queue sizing.
    localparam int FETCH_QUEUE_DEPTH     = 4;
    localparam int FETCH_MAX_OUTSTANDING = 2;

    // Classification of a memory response in the cycle it arrives.
    typedef enum logic [1:0] {
        RSP_NONE,   // nothing returned this cycle
        RSP_KEEP,   // current-epoch word, goes into the instruction FIFO
        RSP_STALE,  // belongs to a flushed fetch stream, dropped
        RSP_ERROR   // nothing was in flight: protocol violation, ignored
    } rsp_kind_e;

    // A new request may issue only if a tag slot is free and every in-flight
    // request, plus this one, is guaranteed a slot in the instruction FIFO.
    function automatic logic fetch_credit(input int count, input int inflight,
                                          input int max_outstnd, input int depth);
        return (inflight < max_outstnd) && ((count + inflight) < depth);
    endfunction

endpackage

// File: rtl/insn_fetch_queue_if.sv
// Handshake bundle between PC, instruction memory, fetch queue and decode.
interface insn_fetch_queue_if
    import insn_fetch_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = INSN_ADDR_PATH,
    parameter int INSN_WIDTH = INSN_PATH
);
    // Program counter side
    logic [ADDR_WIDTH-1:0] pcAddr;
    logic                  pcValid;
    logic                  pcReady;
    logic                  flush;

    // Instruction memory side
    logic                  imemReq;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic                  imemGnt;
    logic                  imemRspValid;
    logic [INSN_WIDTH-1:0] imemRspData;

    // Decode side
    logic                  insnValid;
    logic [INSN_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] insnAddr;
    logic                  insnReady;

    // The fetch queue itself.
    modport slave (
        input  pcAddr, pcValid, flush, imemGnt, imemRspValid, imemRspData, insnReady,
        output pcReady, imemReq, imemAddr, insnValid, insn, insnAddr
    );

    // The surrounding pipeline and memory.
    modport master (
        output pcAddr, pcValid, flush, imemGnt, imemRspValid, imemRspData, insnReady,
        input  pcReady, imemReq, imemAddr, insnValid, insn, insnAddr
    );

endinterface

// File: rtl/insn_fetch_queue_sync_fifo.sv
// Single-clock FIFO with flush; push and pop may coincide at any occupancy.
// Reading an empty FIFO returns zero so downstream sees clean outputs.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

    // Next pointer/occupancy; flush discards everything, including this cycle's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates the read.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/insn_fetch_queue.sv
// Fetch stage: issues PC addresses to instruction memory, tags each request
// with the current epoch, and queues returned words for decode. A redirect
// flips the epoch so responses to the abandoned stream are recognised and dropped.
module insn_fetch_queue
    import insn_fetch_queue_pkg::*;
#(
    parameter int ADDR_WIDTH  = INSN_ADDR_PATH,
    parameter int INSN_WIDTH  = INSN_PATH,
    parameter int DEPTH       = FETCH_QUEUE_DEPTH,
    parameter int MAX_OUTSTND = FETCH_MAX_OUTSTANDING
) (
    input logic               clk,
    input logic               rst,
    insn_fetch_queue_if.slave bus
);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int TAG_CNT_W = $clog2(MAX_OUTSTND) + 1;
    localparam int TAG_W     = ADDR_WIDTH + 1;
    localparam int ENTRY_W   = ADDR_WIDTH + INSN_WIDTH;

    logic                 epoch_q, epoch_d;
    logic [TAG_CNT_W-1:0] inflight_q, inflight_d;

    logic                 credit;
    logic                 imem_req;
    logic                 accept;
    rsp_kind_e            rsp_kind;
    logic                 rsp_pop;

    logic [TAG_W-1:0]     tag_wdata, tag_rdata;
    logic                 tag_full, tag_empty;
    logic [TAG_CNT_W-1:0] tag_count;

    logic                 q_push, q_pop;
    logic [ENTRY_W-1:0]   q_wdata, q_rdata;
    logic                 q_full, q_empty;
    logic [CNT_W-1:0]     q_count;

    // Request side: credit uses start-of-cycle occupancy; nothing issues in reset or on a redirect.
    assign credit   = fetch_credit(int'(q_count), int'(inflight_q), MAX_OUTSTND, DEPTH)
                      && !bus.flush && rst;
    assign imem_req = bus.pcValid && credit;
    assign accept   = imem_req && bus.imemGnt;

    assign bus.imemReq  = imem_req;
    assign bus.imemAddr = bus.pcAddr;
    assign bus.pcReady  = accept;

    // Classify the incoming response against the oldest outstanding tag.
    always_comb begin
        rsp_kind = RSP_NONE;
        if (bus.imemRspValid) begin
            if (inflight_q == '0)
                rsp_kind = RSP_ERROR;
            else if (bus.flush || (tag_rdata[ADDR_WIDTH] != epoch_q))
                rsp_kind = RSP_STALE;
            else
                rsp_kind = RSP_KEEP;
        end
    end

    assign rsp_pop   = (rsp_kind == RSP_KEEP) || (rsp_kind == RSP_STALE);
    assign tag_wdata = {epoch_q, bus.pcAddr};
    assign q_push    = (rsp_kind == RSP_KEEP);
    assign q_wdata   = {tag_rdata[ADDR_WIDTH-1:0], bus.imemRspData};
    // Decode's ready is ignored during a redirect; the FIFO is being cleared anyway.
    assign q_pop     = !q_empty && bus.insnReady && !bus.flush;

    assign bus.insnValid           = !q_empty;
    assign {bus.insnAddr, bus.insn} = q_rdata;

    // Outstanding request count and fetch epoch; a redirect flips the epoch.
    always_comb begin
        epoch_d    = epoch_q ^ bus.flush;
        inflight_d = inflight_q;
        case ({accept, rsp_pop})
            2'b10:   inflight_d = inflight_q + TAG_CNT_W'(1);
            2'b01:   inflight_d = inflight_q - TAG_CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Epoch and inflight registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epoch_q    <= 1'b0;
            inflight_q <= '0;
        end else begin
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
        end
    end

    // Tags survive a redirect: in-flight responses must still be matched and discarded.
    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTND),
        .CNT_W (TAG_CNT_W)
    ) u_tag_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (rsp_pop),
        .flush_i (1'b0),
        .wdata_i (tag_wdata),
        .rdata_o (tag_rdata),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_insn_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (bus.flush),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        bus.imemRspValid |-> (inflight_q != '0));

    a_insn_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        q_push |-> (!q_full || q_pop));

    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        accept |-> (!tag_full || rsp_pop));

    a_inflight_tracks_tags: assert property (@(posedge clk) disable iff (!rst)
        (inflight_q == tag_count) && (tag_empty == (inflight_q == '0)));

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for the fetch queue: reset, streaming, backpressure,
// long memory latency, redirect, and a standalone full-FIFO push+pop check.
module tb_insn_fetch_queue;
    import insn_fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    insn_fetch_queue_if #(.ADDR_WIDTH(INSN_ADDR_PATH), .INSN_WIDTH(INSN_PATH)) bus ();

    insn_fetch_queue #(
        .ADDR_WIDTH  (INSN_ADDR_PATH),
        .INSN_WIDTH  (INSN_PATH),
        .DEPTH       (4),
        .MAX_OUTSTND (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic       f_push, f_pop, f_flush;
    logic [7:0] f_wdata, f_rdata;
    logic       f_full, f_empty;
    logic [2:0] f_count;

    sync_fifo #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .flush_i (f_flush),
        .wdata_i (f_wdata),
        .rdata_o (f_rdata),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hFACE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stimulus, let combinational outputs settle, log it.
    task automatic drive(input logic pv, input logic [31:0] pa, input logic rv,
                         input logic [31:0] ra, input logic rdy, input logic fl);
        bus.pcValid      = pv;
        bus.pcAddr       = pa;
        bus.imemRspValid = rv;
        bus.imemRspData  = rv ? word_of(ra) : 32'h0;
        bus.insnReady    = rdy;
        bus.flush        = fl;
        #1;
        $display("t=%0t pcValid=%b pcAddr=%h rsp=%b/%h rdy=%b flush=%b | req=%b pcReady=%b insnValid=%b insnAddr=%h insn=%h",
                 $time, pv, pa, rv, bus.imemRspData, rdy, fl, bus.imemReq, bus.pcReady,
                 bus.insnValid, bus.insnAddr, bus.insn);
    endtask

    initial begin
        rst         = 1'b0;
        bus.imemGnt = 1'b1;
        f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_wdata = 8'h00;

        // ---- reset with pcValid held high ----
        drive(1, INSN_RESET_VECTOR, 0, 0, 0, 0);
        cycle(); cycle();
        drive(1, INSN_RESET_VECTOR, 0, 0, 0, 0);
        chk("rst_imemReq",   bus.imemReq,   0);
        chk("rst_pcReady",   bus.pcReady,   0);
        chk("rst_insnValid", bus.insnValid, 0);
        chk("rst_insn",      bus.insn,      0);
        chk("rst_insnAddr",  bus.insnAddr,  0);

        // ---- streaming, latency 1, decode always ready ----
        cycle(); rst = 1'b1;
        drive(1, INSN_RESET_VECTOR, 0, 0, 1, 0);
        chk("c0_imemReq",  bus.imemReq,  1);
        chk("c0_imemAddr", bus.imemAddr, INSN_RESET_VECTOR);
        chk("c0_pcReady",  bus.pcReady,  1);
        cycle(); drive(1, INSN_RESET_VECTOR + INSN_PC_INC, 1, 32'h0, 1, 0);
        chk("c1_pcReady",   bus.pcReady,   1);
        chk("c1_insnValid", bus.insnValid, 0);
        cycle(); drive(1, 32'h8, 1, 32'h4, 1, 0);
        chk("c2_insnValid", bus.insnValid, 1);
        chk("c2_insnAddr",  bus.insnAddr,  32'h0);
        chk("c2_insn",      bus.insn,      word_of(32'h0));
        cycle(); drive(1, 32'hC, 1, 32'h8, 1, 0);
        chk("c3_pcReady",  bus.pcReady,  1);
        chk("c3_insnAddr", bus.insnAddr, 32'h4);
        cycle(); drive(0, 32'h10, 1, 32'hC, 1, 0);
        chk("c4_insnAddr", bus.insnAddr, 32'h8);
        cycle(); drive(0, 32'h10, 0, 0, 1, 0);
        chk("c5_insnAddr", bus.insnAddr, 32'hC);
        chk("c5_insn",     bus.insn,     word_of(32'hC));
        cycle(); drive(0, 32'h10, 0, 0, 1, 0);
        chk("c6_insnValid", bus.insnValid, 0);

        // ---- backpressure: decode stalled until four words are queued ----
        cycle(); drive(1, 32'h20, 0, 0, 0, 0);
        chk("b0_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h24, 1, 32'h20, 0, 0);
        chk("b1_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h28, 1, 32'h24, 0, 0);
        chk("b2_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h2C, 1, 32'h28, 0, 0);
        chk("b3_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h30, 1, 32'h2C, 0, 0);
        chk("b4_pcReady", bus.pcReady, 0);
        chk("b4_imemReq", bus.imemReq, 0);
        cycle(); drive(1, 32'h30, 0, 0, 1, 0);
        chk("b5_imemReq",  bus.imemReq,  0);
        chk("b5_insnAddr", bus.insnAddr, 32'h20);
        cycle(); drive(1, 32'h30, 0, 0, 0, 0);
        chk("b6_pcReady",  bus.pcReady,  1);
        chk("b6_insnAddr", bus.insnAddr, 32'h24);
        cycle(); drive(0, 32'h34, 1, 32'h30, 1, 0);
        chk("b7_insnAddr", bus.insnAddr, 32'h24);
        cycle(); drive(0, 32'h34, 0, 0, 1, 0);
        chk("b8_insnAddr", bus.insnAddr, 32'h28);
        cycle(); drive(0, 32'h34, 0, 0, 1, 0);
        chk("b9_insnAddr", bus.insnAddr, 32'h2C);
        cycle(); drive(0, 32'h34, 0, 0, 1, 0);
        chk("b10_insnAddr", bus.insnAddr, 32'h30);
        chk("b10_insn",     bus.insn,     word_of(32'h30));
        cycle(); drive(0, 32'h34, 0, 0, 1, 0);
        chk("b11_insnValid", bus.insnValid, 0);

        // ---- latency 3: at most two requests in flight ----
        cycle(); drive(1, 32'h40, 0, 0, 1, 0);
        chk("l0_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h44, 0, 0, 1, 0);
        chk("l1_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h48, 0, 0, 1, 0);
        chk("l2_pcReady", bus.pcReady, 0);
        chk("l2_imemReq", bus.imemReq, 0);
        cycle(); drive(1, 32'h48, 1, 32'h40, 1, 0);
        chk("l3_pcReady", bus.pcReady, 0);
        cycle(); drive(1, 32'h48, 1, 32'h44, 1, 0);
        chk("l4_pcReady",  bus.pcReady,  1);
        chk("l4_insnAddr", bus.insnAddr, 32'h40);
        cycle(); drive(1, 32'h4C, 0, 0, 1, 0);
        chk("l5_pcReady",  bus.pcReady,  1);
        chk("l5_insnAddr", bus.insnAddr, 32'h44);
        cycle(); drive(0, 32'h50, 0, 0, 1, 0);
        chk("l6_insnValid", bus.insnValid, 0);
        cycle(); drive(0, 32'h50, 1, 32'h48, 1, 0);
        chk("l7_insnValid", bus.insnValid, 0);
        cycle(); drive(0, 32'h50, 1, 32'h4C, 1, 0);
        chk("l8_insnAddr", bus.insnAddr, 32'h48);
        chk("l8_insn",     bus.insn,     word_of(32'h48));
        cycle(); drive(0, 32'h50, 0, 0, 1, 0);
        chk("l9_insnAddr", bus.insnAddr, 32'h4C);
        cycle(); drive(0, 32'h50, 0, 0, 1, 0);
        chk("l10_insnValid", bus.insnValid, 0);

        // ---- redirect with two queued and two in flight ----
        cycle(); drive(1, 32'h60, 0, 0, 0, 0);
        chk("f0_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h64, 1, 32'h60, 0, 0);
        chk("f1_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h68, 1, 32'h64, 0, 0);
        chk("f2_pcReady", bus.pcReady, 1);
        cycle(); drive(1, 32'h6C, 0, 0, 0, 0);
        chk("f3_pcReady",  bus.pcReady,  1);
        chk("f3_insnAddr", bus.insnAddr, 32'h60);
        cycle(); drive(1, 32'h100, 1, 32'h68, 1, 1);
        chk("f4_imemReq",   bus.imemReq,   0);
        chk("f4_pcReady",   bus.pcReady,   0);
        chk("f4_insnValid", bus.insnValid, 1);
        cycle(); drive(1, 32'h100, 1, 32'h6C, 0, 0);
        chk("f5_insnValid", bus.insnValid, 0);
        chk("f5_pcReady",   bus.pcReady,   1);
        cycle(); drive(0, 32'h104, 0, 0, 0, 0);
        chk("f6_insnValid", bus.insnValid, 0);
        cycle(); drive(0, 32'h104, 1, 32'h100, 0, 0);
        chk("f7_insnValid", bus.insnValid, 0);
        cycle(); drive(0, 32'h104, 0, 0, 1, 0);
        chk("f8_insnValid", bus.insnValid, 1);
        chk("f8_insnAddr",  bus.insnAddr,  32'h100);
        chk("f8_insn",      bus.insn,      word_of(32'h100));
        cycle(); drive(0, 32'h104, 0, 0, 1, 0);
        chk("f9_insnValid", bus.insnValid, 0);

        // ---- standalone FIFO: push and pop together while full ----
        cycle(); f_push = 1'b1; f_wdata = 8'h11; #1;
        chk("u0_empty", f_empty, 1);
        cycle(); f_wdata = 8'h22;
        cycle(); f_wdata = 8'h33;
        cycle(); f_wdata = 8'h44;
        cycle(); f_push = 1'b0; #1;
        chk("u4_full",  f_full,  1);
        chk("u4_count", f_count, 4);
        chk("u4_head",  f_rdata, 8'h11);
        f_push = 1'b1; f_pop = 1'b1; f_wdata = 8'h55;
        cycle(); f_push = 1'b0; f_pop = 1'b0; #1;
        chk("u5_count", f_count, 4);
        chk("u5_full",  f_full,  1);
        chk("u5_head",  f_rdata, 8'h22);
        f_pop = 1'b1;
        cycle(); #1; chk("u6_head", f_rdata, 8'h33);
        cycle(); #1; chk("u7_head", f_rdata, 8'h44);
        cycle(); #1; chk("u8_head", f_rdata, 8'h55);
        cycle(); f_pop = 1'b0; #1;
        chk("u9_empty", f_empty, 1);
        f_push = 1'b1; f_wdata = 8'h66;
        cycle(); f_push = 1'b0; f_flush = 1'b1; #1;
        chk("u10_count", f_count, 1);
        cycle(); f_flush = 1'b0; #1;
        chk("u11_count", f_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
